// File: rtl/pe_spi_pkg.sv
// Shared definitions for the reversible PE SPI link: frame layout, command codes
// and the host batch state encoding. The PE slave side imports this package too.
package pe_spi_pkg;

    localparam int FRAME_BITS     = 26;
    localparam int HDR_BITS       = 8;
    localparam int PAYLOAD_BITS   = 18;
    localparam int HDR_ADDR_BITS  = 6;
    localparam int FRAME_DATA_BITS = 16;

    // Bit offsets inside the 26-bit frame (MSB is shifted out first).
    localparam int HDR_RW_BIT     = 25;
    localparam int HDR_RSVD_BIT   = 24;
    localparam int HDR_ADDR_LSB   = 18;
    localparam int CMD_LSB        = 16;
    localparam int DATA_LSB       = 0;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } host_state_t;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic                       rw,
        input logic [HDR_ADDR_BITS-1:0]   addr,
        input logic [1:0]                 cmd,
        input logic [FRAME_DATA_BITS-1:0] data
    );
        return {rw, 1'b0, addr, cmd, data};
    endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// Mode-0 SPI frame shifter: one 26-bit full-duplex frame per launch, MSB first,
// with SCK_DIV clk cycles per SCK half-period. Owns all four SPI pins.
module spi_frame_engine
    import pe_spi_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  launch_i,
    input  logic [FRAME_BITS-1:0] tx_frame_i,
    input  logic                  spi_miso_i,
    output logic                  frame_busy_o,
    output logic                  frame_end_o,
    output logic [FRAME_BITS-1:0] rx_frame_o,
    output logic                  spi_clk_o,
    output logic                  spi_csn_o,
    output logic                  spi_mosi_o
);

    localparam int DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int HALF_LAST = 2 * FRAME_BITS + 1;
    localparam int PH_W      = $clog2(HALF_LAST + 1);

    logic                  active_q, active_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [PH_W-1:0]       ph_next;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic                  sck_q, sck_d;
    logic                  csn_q, csn_d;
    logic                  end_q, end_d;

    assign ph_next = ph_q + PH_W'(1);

    // ph counts SCK half-periods since launch: odd values are rising edges,
    // even values falling edges, and the final count releases chip select.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        ph_d     = ph_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sck_d    = sck_q;
        csn_d    = csn_q;
        end_d    = 1'b0;

        if (!active_q) begin
            if (launch_i) begin
                active_d = 1'b1;
                csn_d    = 1'b0;
                sck_d    = 1'b0;
                div_d    = '0;
                ph_d     = '0;
                tx_d     = tx_frame_i;
                rx_d     = '0;
            end
        end else if (div_q == DIV_W'(SCK_DIV - 1)) begin
            div_d = '0;
            ph_d  = ph_next;
            if (ph_next == PH_W'(HALF_LAST)) begin
                active_d = 1'b0;
                csn_d    = 1'b1;
                sck_d    = 1'b0;
                tx_d     = '0;
                end_d    = 1'b1;
            end else if (ph_next[0]) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[FRAME_BITS-2:0], spi_miso_i};
            end else begin
                sck_d = 1'b0;
                tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            ph_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sck_q    <= 1'b0;
            csn_q    <= 1'b1;
            end_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            ph_q     <= ph_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sck_q    <= sck_d;
            csn_q    <= csn_d;
            end_q    <= end_d;
        end
    end

    assign frame_busy_o = active_q;
    assign frame_end_o  = end_q;
    assign rx_frame_o   = rx_q;
    assign spi_clk_o    = sck_q;
    assign spi_csn_o    = csn_q;
    assign spi_mosi_o   = tx_q[FRAME_BITS-1];

endmodule

// File: rtl/pe_spi_host.sv
// Batch host for the PE SPI slave: loads DATA_NUM operands, kicks the PE, waits
// for the pipeline to drain, then reads every result back onto a valid-only stream.
module pe_spi_host
    import pe_spi_pkg::*;
#(
    parameter int DATA_NUM    = 64,
    parameter int DATA_WIDTH  = 16,
    parameter int CMD_WIDTH   = 2,
    parameter int ADDR_WIDTH  = 6,
    parameter int SCK_DIV     = 4,
    parameter int WAIT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [DATA_WIDTH-1:0] op_data_i,
    output logic                  res_valid_o,
    output logic [ADDR_WIDTH-1:0] res_addr_o,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_clk_o,
    output logic                  spi_csn_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    host_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [15:0]           wait_q, wait_d;
    logic                  pend_q, pend_d;
    logic                  gap_q, gap_d;
    logic                  ready_q, ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  launch;
    logic [FRAME_BITS-1:0] tx_frame;
    logic [FRAME_BITS-1:0] rx_frame;
    logic                  frame_busy;
    logic                  frame_end;
    logic                  last_idx;
    logic                  slot_free;
    logic                  unused_rx;

    assign last_idx  = (idx_q == ADDR_WIDTH'(DATA_NUM - 1));
    // gap_q holds off the cycle after frame end so chip select stays high >= 2 cycles.
    assign slot_free = !pend_q && !gap_q && !frame_end;
    assign unused_rx = ^{rx_frame[FRAME_BITS-1:DATA_WIDTH], frame_busy, 1'(CMD_WIDTH)};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        ready_d     = ready_q;
        res_valid_d = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        gap_d       = frame_end;
        launch      = 1'b0;
        tx_frame    = '0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                if (start_i) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ready_q && op_valid_i) begin
                    launch   = 1'b1;
                    tx_frame = pack_frame(1'b1, HDR_ADDR_BITS'(idx_q), CMD_WRITE,
                                          FRAME_DATA_BITS'(op_data_i));
                    ready_d  = 1'b0;
                end
                if (gap_q) begin
                    ready_d = 1'b1;
                end
                if (frame_end) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_KICK;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_KICK: begin
                if (slot_free) begin
                    launch   = 1'b1;
                    tx_frame = pack_frame(1'b1, '0, CMD_START, '0);
                end
                if (frame_end) begin
                    state_d = ST_WAIT;
                    wait_d  = 16'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (wait_q == 16'd0) begin
                    state_d = ST_READ;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_READ: begin
                if (slot_free) begin
                    launch   = 1'b1;
                    tx_frame = pack_frame(1'b0, HDR_ADDR_BITS'(idx_q), CMD_NONE, '0);
                end
                if (frame_end) begin
                    res_valid_d = 1'b1;
                    res_addr_d  = idx_q;
                    res_data_d  = rx_frame[DATA_WIDTH-1:0];
                    if (last_idx) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pend_d = launch ? 1'b1 : (frame_end ? 1'b0 : pend_q);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            pend_q      <= 1'b0;
            gap_q       <= 1'b0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    spi_frame_engine #(
        .SCK_DIV(SCK_DIV)
    ) u_engine (
        .clk         (clk),
        .rst_n       (rst_n),
        .launch_i    (launch),
        .tx_frame_i  (tx_frame),
        .spi_miso_i  (spi_miso_i),
        .frame_busy_o(frame_busy),
        .frame_end_o (frame_end),
        .rx_frame_o  (rx_frame),
        .spi_clk_o   (spi_clk_o),
        .spi_csn_o   (spi_csn_o),
        .spi_mosi_o  (spi_mosi_o)
    );

    assign op_ready_o  = ready_q;
    assign res_valid_o = res_valid_q;
    assign res_addr_o  = res_addr_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
